branch_resolve_bht: RTL and testbench
=====================================

Name: branch_resolve_bht

Overview:
- Parametrised branch resolution unit for the pipelined RISC-V core.
- Execute side: evaluates the branch condition on forwarded operands (same 3-bit br_type encoding as the existing comparator), checks it against the fetch-time prediction, and raises a redirect on mismatch.
- Fetch side: provides predictions from a PC-indexed table of 2-bit saturating counters (BHT).
- Trains the BHT on every resolved conditional branch and keeps saturating branch/mispredict statistics counters.

Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, >=2
- IDX_LSB, 2, lowest PC bit used for the BHT index
- STAT_W, 32, width of statistics counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- pc_f  in  XLEN  fetch PC for prediction lookup
- pred_taken_f  out  1  fetch-stage prediction
- valid_e  in  1  execute stage holds a branch/jump
- stall_e  in  1  execute stage stalled; no state update
- pc_e  in  XLEN  PC of execute-stage instruction
- rdata_FA  in  XLEN  forwarded operand A
- rdata_FB  in  XLEN  forwarded operand B
- br_type  in  3  000 eq, 001 ne, 010 lt, 011 ge, 100 ltu, 101 geu, 110 never, 111 always
- pred_taken_e  in  1  prediction carried down the pipe with the instruction
- target_e  in  XLEN  computed branch target
- br_taken  out  1  resolved outcome
- mispredict  out  1  registered redirect request
- redirect_pc  out  XLEN  registered redirect PC
- n_branches  out  STAT_W  resolved conditional branches
- n_mispred  out  STAT_W  mispredicted conditional branches

Behaviour:
- Index: idx(pc) = pc[IDX_LSB +: log2(BHT_ENTRIES)].
- Prediction: pred_taken_f = bht[idx(pc_f)][1]. Combinational, no latency.
- br_taken: combinational on the execute inputs. Signed compares for lt/ge, unsigned for ltu/geu.
  - Forced to 0 when valid_e = 0.
  - 110 -> 0, 111 -> 1.
- resolve = valid_e & ~stall_e.
- cond = br_type not in {110, 111}. Jumps (111) never train the BHT and never count.
- Mispredict, registered (latency 1):
  - On resolve with br_taken != pred_taken_e, next cycle mispredict = 1 and redirect_pc = br_taken ? target_e : pc_e + 4 (mod 2^XLEN).
  - Otherwise mispredict = 0 next cycle.
  - redirect_pc holds its last value when mispredict is 0.
  - Applies to jumps as well: a jump predicted not-taken redirects.
- BHT update, on resolve & cond:
  - Taken: counter += 1, saturating at 11.
  - Not taken: counter -= 1, saturating at 00.
- Same-index read/write in one cycle: pred_taken_f returns the pre-update value. No bypass.
- Statistics, on resolve & cond:
  - n_branches += 1.
  - n_mispred += 1 if mispredicted.
  - Both saturate at all-ones and never wrap.
- stall_e = 1: no BHT, statistics or mispredict change. mispredict drops to 0 after one cycle; a single redirect pulse per branch.
- Reset (rst = 1 at posedge), overriding all other inputs in that cycle:
  - All BHT entries = 01 (weakly not-taken).
  - mispredict = 0, redirect_pc = 0, n_branches = 0, n_mispred = 0.
  - A resolution arriving in the reset cycle is discarded.
  - pred_taken_f after reset = 0.

Decomposition:
- Shared package core_pkg:
  - br_type_e enum (BR_EQ..BR_ALWAYS, values as above).
  - BHT_INIT = 2'b01.
  - Saturating-counter next-state function.
- Sub-module br_compare: the combinational condition evaluator (XLEN-parametrised), instantiated once. The BHT array and counters stay in the top.

Test Plan:
- Reset, then pc_f = 0x100 -> pred_taken_f = 0; n_branches = 0, n_mispred = 0.
- BEQ at pc_e = 0x100, A = B = 5, pred_taken_e = 0, target 0x140 -> br_taken = 1; next cycle mispredict = 1, redirect_pc = 0x140; bht[idx] = 10; pred for 0x100 now 1; n_mispred = 1.
- Three more taken BEQ at 0x100 -> counter saturates at 11. Then four not-taken -> 00, then a fifth not-taken stays 00. No wrap.
- BLT A = 0xFFFFFFFF, B = 1 -> taken. BLTU with same operands -> not taken, pred_taken_e = 0 -> no mispredict, counter decrements.
- JAL (111) with pred_taken_e = 0 at 0x200 -> mispredict, redirect_pc = target_e; BHT and statistics unchanged. BHT stays unchanged also with stall_e = 1: no update, no pulse.
- STAT_W = 4: 16 branches -> n_branches stays 0xF. Assert rst mid-stream with valid_e = 1 -> all outputs zero and that branch is not counted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared branch-unit definitions: branch condition encoding, BHT reset value
// and the 2-bit saturating counter step.
package core_pkg;

    typedef enum logic [2:0] {
        BR_EQ     = 3'b000,
        BR_NE     = 3'b001,
        BR_LT     = 3'b010,
        BR_GE     = 3'b011,
        BR_LTU    = 3'b100,
        BR_GEU    = 3'b101,
        BR_NEVER  = 3'b110,
        BR_ALWAYS = 3'b111
    } br_type_e;

    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b1_00: nxt = 2'b01;
            3'b1_01: nxt = 2'b10;
            3'b1_10: nxt = 2'b11;
            3'b0_01: nxt = 2'b00;
            3'b0_10: nxt = 2'b01;
            3'b0_11: nxt = 2'b10;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/br_compare.sv
// Combinational branch condition evaluator on forwarded operands.
module br_compare
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      br_type,
    output logic            taken
);

    // Condition select; lt/ge are signed, ltu/geu unsigned.
    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_EQ:     taken = (a == b);
            BR_NE:     taken = (a != b);
            BR_LT:     taken = ($signed(a) <  $signed(b));
            BR_GE:     taken = ($signed(a) >= $signed(b));
            BR_LTU:    taken = (a <  b);
            BR_GEU:    taken = (a >= b);
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit: execute-stage condition check with registered redirect,
// PC-indexed 2-bit BHT for fetch prediction, and saturating branch statistics.
module branch_resolve_bht
    import core_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_LSB     = 2,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_f,
    output logic              pred_taken_f,
    input  logic              valid_e,
    input  logic              stall_e,
    input  logic [XLEN-1:0]   pc_e,
    input  logic [XLEN-1:0]   rdata_FA,
    input  logic [XLEN-1:0]   rdata_FB,
    input  logic [2:0]        br_type,
    input  logic              pred_taken_e,
    input  logic [XLEN-1:0]   target_e,
    output logic              br_taken,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] n_branches,
    output logic [STAT_W-1:0] n_mispred
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam logic [XLEN-1:0]   PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [1:0]        bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0]  idx_f_s;
    logic [IDX_W-1:0]  idx_e_s;
    logic              cmp_taken_s;
    logic              resolve_s;
    logic              cond_s;
    logic              wrong_s;
    logic              mispredict_r;
    logic [XLEN-1:0]   redirect_pc_r;
    logic [STAT_W-1:0] n_branches_r;
    logic [STAT_W-1:0] n_mispred_r;
    logic              unused_pc_f_s;

    assign idx_f_s       = pc_f[IDX_LSB +: IDX_W];
    assign idx_e_s       = pc_e[IDX_LSB +: IDX_W];
    assign unused_pc_f_s = ^pc_f;

    br_compare #(.XLEN(XLEN)) u_br_compare (
        .a       (rdata_FA),
        .b       (rdata_FB),
        .br_type (br_type),
        .taken   (cmp_taken_s)
    );

    assign br_taken     = valid_e & cmp_taken_s;
    assign resolve_s    = valid_e & ~stall_e;
    assign cond_s       = (br_type != 3'b110) && (br_type != 3'b111);
    assign wrong_s      = (br_taken != pred_taken_e);
    // Read sees the pre-update counter on a same-cycle write; no bypass.
    assign pred_taken_f = bht_r[idx_f_s][1];

    // BHT training on resolved conditional branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= BHT_INIT;
            end
        end else if (resolve_s && cond_s) begin
            bht_r[idx_e_s] <= sat_ctr_next(bht_r[idx_e_s], br_taken);
        end
    end

    // One-cycle redirect pulse; redirect_pc holds between mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_r  <= 1'b0;
            redirect_pc_r <= {XLEN{1'b0}};
        end else if (resolve_s && wrong_s) begin
            mispredict_r  <= 1'b1;
            redirect_pc_r <= br_taken ? target_e : (pc_e + PC_STEP);
        end else begin
            mispredict_r  <= 1'b0;
        end
    end

    // Saturating statistics for conditional branches only.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_branches_r <= {STAT_W{1'b0}};
            n_mispred_r  <= {STAT_W{1'b0}};
        end else if (resolve_s && cond_s) begin
            if (n_branches_r != STAT_MAX) begin
                n_branches_r <= n_branches_r + STAT_ONE;
            end
            if (wrong_s && (n_mispred_r != STAT_MAX)) begin
                n_mispred_r <= n_mispred_r + STAT_ONE;
            end
        end
    end

    assign mispredict  = mispredict_r;
    assign redirect_pc = redirect_pc_r;
    assign n_branches  = n_branches_r;
    assign n_mispred   = n_mispred_r;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Randomized bench for branch_resolve_bht against a behavioural model of the
// branch rules, BHT counters (as integers 0..3) and saturating statistics.
module tb_branch_resolve_bht;

    localparam int XLEN = 32;
    localparam int BHT_ENTRIES = 64;
    localparam int IDX_LSB = 2;
    localparam int STAT_W = 4;
    localparam int STAT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [XLEN-1:0]   pc_f;
    logic              pred_taken_f;
    logic              valid_e;
    logic              stall_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   rdata_FA;
    logic [XLEN-1:0]   rdata_FB;
    logic [2:0]        br_type;
    logic              pred_taken_e;
    logic [XLEN-1:0]   target_e;
    logic              br_taken;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic [STAT_W-1:0] n_branches;
    logic [STAT_W-1:0] n_mispred;

    int n_tests = 0;
    int n_fail  = 0;

    int          mdl_bht [BHT_ENTRIES];
    bit          mdl_misp;
    logic [31:0] mdl_rpc;
    int          mdl_nb;
    int          mdl_nm;

    always #5 clk = ~clk;

    branch_resolve_bht #(
        .XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .IDX_LSB(IDX_LSB), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .valid_e(valid_e), .stall_e(stall_e), .pc_e(pc_e),
        .rdata_FA(rdata_FA), .rdata_FB(rdata_FB), .br_type(br_type),
        .pred_taken_e(pred_taken_e), .target_e(target_e), .br_taken(br_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .n_branches(n_branches), .n_mispred(n_mispred)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> IDX_LSB) % BHT_ENTRIES);
    endfunction

    function automatic bit ref_taken();
        if (!valid_e) return 1'b0;
        case (br_type)
            3'd0: return rdata_FA == rdata_FB;
            3'd1: return rdata_FA != rdata_FB;
            3'd2: return $signed(rdata_FA) < $signed(rdata_FB);
            3'd3: return $signed(rdata_FA) >= $signed(rdata_FB);
            3'd4: return rdata_FA < rdata_FB;
            3'd5: return rdata_FA >= rdata_FB;
            3'd6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_update();
        bit t;
        bit cond;
        t = ref_taken();
        cond = (br_type < 3'd6);
        if (rst) begin
            foreach (mdl_bht[i]) mdl_bht[i] = 1;
            mdl_misp = 1'b0;
            mdl_rpc  = 32'h0;
            mdl_nb   = 0;
            mdl_nm   = 0;
        end else begin
            mdl_misp = 1'b0;
            if (valid_e && !stall_e) begin
                if (t != pred_taken_e) begin
                    mdl_misp = 1'b1;
                    mdl_rpc  = t ? target_e : pc_e + 32'd4;
                end
                if (cond) begin
                    if (t) mdl_bht[idx_of(pc_e)] = (mdl_bht[idx_of(pc_e)] == 3) ? 3 : mdl_bht[idx_of(pc_e)] + 1;
                    else   mdl_bht[idx_of(pc_e)] = (mdl_bht[idx_of(pc_e)] == 0) ? 0 : mdl_bht[idx_of(pc_e)] - 1;
                    if (mdl_nb < STAT_MAX) mdl_nb++;
                    if (t != pred_taken_e && mdl_nm < STAT_MAX) mdl_nm++;
                end
            end
        end
    endtask

    // Checks combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic cycle();
        @(negedge clk);
        chk("pred_taken_f", 64'(pred_taken_f), 64'(mdl_bht[idx_of(pc_f)] >= 2));
        chk("br_taken", 64'(br_taken), 64'(ref_taken()));
        @(posedge clk);
        model_update();
        #1;
        chk("mispredict", 64'(mispredict), 64'(mdl_misp));
        chk("redirect_pc", 64'(redirect_pc), 64'(mdl_rpc));
        chk("n_branches", 64'(n_branches), 64'(mdl_nb));
        chk("n_mispred", 64'(n_mispred), 64'(mdl_nm));
    endtask

    task automatic drive(input bit v, input bit s, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] t, input bit p, input logic [31:0] tgt);
        valid_e = v; stall_e = s; pc_e = pc; rdata_FA = a; rdata_FB = b;
        br_type = t; pred_taken_e = p; target_e = tgt;
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 5))
            0: return 32'h100;
            1: return 32'h104;
            2: return 32'h200;
            3: return 32'h108;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        foreach (mdl_bht[i]) mdl_bht[i] = 1;
        mdl_misp = 1'b0; mdl_rpc = 32'h0; mdl_nb = 0; mdl_nm = 0;
        rst = 1'b1; pc_f = 32'h100;
        drive(1'b1, 1'b0, 32'h100, 32'd5, 32'd5, 3'd0, 1'b0, 32'h140);
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h0);
        chk("reset_pred", 64'(pred_taken_f), 64'd0);
        chk("reset_nb", 64'(n_branches), 64'd0);
        chk("reset_nm", 64'(n_mispred), 64'd0);
        cycle();

        // First taken BEQ mispredicts and trains 01 -> 10.
        drive(1'b1, 1'b0, 32'h100, 32'd5, 32'd5, 3'd0, 1'b0, 32'h140);
        cycle();
        chk("beq_misp", 64'(mispredict), 64'd1);
        chk("beq_redir", 64'(redirect_pc), 64'h140);
        chk("beq_pred", 64'(pred_taken_f), 64'd1);
        chk("beq_nm", 64'(n_mispred), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h100, 32'd7, 32'd7, 3'd0, 1'b1, 32'h140);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h100, 32'd7, 32'd8, 3'd0, 1'b0, 32'h140);
            cycle();
        end
        chk("sat_low_pred", 64'(pred_taken_f), 64'd0);
        // Signed vs unsigned on the same operands.
        drive(1'b1, 1'b0, 32'h104, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b1, 32'h180);
        cycle();
        drive(1'b1, 1'b0, 32'h104, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0, 32'h180);
        cycle();
        chk("bltu_nomisp", 64'(mispredict), 64'd0);
        // Jump redirects without training or counting; stalled jump does nothing.
        pc_f = 32'h200;
        drive(1'b1, 1'b0, 32'h200, 32'd0, 32'd0, 3'd7, 1'b0, 32'h400);
        cycle();
        chk("jal_redir", 64'(redirect_pc), 64'h400);
        drive(1'b1, 1'b1, 32'h200, 32'd3, 32'd3, 3'd0, 1'b0, 32'h500);
        cycle();
        chk("stall_nopulse", 64'(mispredict), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h0);
        cycle();
        // Saturate statistics, then reset with a live resolution.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, pick_pc(), $urandom, $urandom, 3'($urandom_range(0, 5)), 1'($urandom), $urandom);
            cycle();
        end
        chk("stat_sat", 64'(n_branches), 64'hF);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h100, 32'd1, 32'd1, 3'd0, 1'b0, 32'h140);
        cycle();
        rst = 1'b0;
        chk("midrst_nb", 64'(n_branches), 64'd0);
        chk("midrst_misp", 64'(mispredict), 64'd0);
        chk("midrst_rpc", 64'(redirect_pc), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            pc_f = pick_pc();
            a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd2;
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), pick_pc(), a,
                  ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd2),
                  3'($urandom_range(0, 7)), 1'($urandom), $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
